// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle main control unit: FSM states,
// RV32I opcodes, ALUOp and ALU B-operand select encodings, control vector.
package cu_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StMemAddr,
        StMemRd,
        StMemWr,
        StWbAlu,
        StWbMem,
        StBranch
    } cu_state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    // ALUOp encodings, also consumed by the ALU control unit
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpRType = 2'b10;
    localparam logic [1:0] AluOpIType = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_inst;
    } cu_ctrl_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OpR) || (op == OpIAlu) || (op == OpLoad) ||
               (op == OpStore) || (op == OpBranch);
    endfunction

endpackage

// File: rtl/main_cu_out_decode.sv
// Combinational decode of FSM state (plus opcode and gating flags) into the
// datapath control vector. Everything not driven for a state stays 0.
module main_cu_out_decode
    import cu_pkg::*;
(
    input  cu_state_e  state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output cu_ctrl_t   ctrl
);

    // Moore outputs per state; only FETCH/BRANCH PC writes look at inputs
    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SrcBFour;
                ctrl.alu_op    = AluOpAdd;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            StDecode: begin
                // Precompute branch target into ALUOut
                ctrl.alu_src_b    = SrcBImm;
                ctrl.alu_op       = AluOpAdd;
                ctrl.illegal_inst = !is_legal_op(opcode);
            end
            StExecR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBRs2;
                ctrl.alu_op    = AluOpRType;
            end
            StExecI: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpIType;
            end
            StMemAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpAdd;
            end
            StMemRd: begin
                ctrl.mem_req = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
            end
            StWbAlu: begin
                ctrl.reg_write = 1'b1;
            end
            StWbMem: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBRs2;
                ctrl.alu_op    = AluOpSub;
                ctrl.pc_src    = 1'b1;
                ctrl.pc_write  = zero;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_cu_fsm.sv
// Multi-cycle main control unit: state register, next-state sequencing and
// retired-instruction counter. Output decode lives in main_cu_out_decode.
module main_cu_fsm
    import cu_pkg::*;
#(
    parameter int unsigned W_INSTRET = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          inst,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           ALUOp,
    output logic                 illegal_inst,
    output logic [W_INSTRET-1:0] instret
);

    cu_state_e             state_q, state_d;
    logic                  retire;
    logic [W_INSTRET-1:0]  instret_q;
    logic [6:0]            opcode;
    cu_ctrl_t              ctrl;
    logic                  unused_inst;

    assign opcode      = inst[6:0];
    assign unused_inst = ^inst[31:7];

    // Next state and retire strobe
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StIdle:    state_d = StFetch;
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpR:              state_d = StExecR;
                    OpIAlu:           state_d = StExecI;
                    OpLoad, OpStore:  state_d = StMemAddr;
                    OpBranch:         state_d = StBranch;
                    default:          state_d = StFetch;  // illegal: refetch, no retire
                endcase
            end
            StExecR, StExecI: state_d = StWbAlu;
            StMemAddr: state_d = (opcode == OpStore) ? StMemWr : StMemRd;
            StMemRd:   if (mem_ready) state_d = StWbMem;
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StWbAlu, StWbMem, StBranch: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default:   state_d = StIdle;
        endcase
    end

    // State register; async reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + W_INSTRET'(1);
        end
    end

    main_cu_out_decode u_out_decode (
        .state     (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    assign mem_req      = ctrl.mem_req;
    assign mem_we       = ctrl.mem_we;
    assign ir_write     = ctrl.ir_write;
    assign pc_write     = ctrl.pc_write;
    assign pc_src       = ctrl.pc_src;
    assign reg_write    = ctrl.reg_write;
    assign mem_to_reg   = ctrl.mem_to_reg;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign ALUOp        = ctrl.alu_op;
    assign illegal_inst = ctrl.illegal_inst;
    assign instret      = instret_q;

endmodule

// File: tb/tb_main_cu_fsm.sv
// Directed bench for main_cu_fsm. A 32-bit and a 4-bit-counter instance share
// stimulus; per-cycle control vectors are compared to hand-derived constants.
module tb_main_cu_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg;
    logic        alu_src_a, illegal_inst;
    logic [1:0]  alu_src_b, alu_op;
    logic [31:0] instret;

    logic        w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_pc_src, w_reg_write;
    logic        w_mem_to_reg, w_alu_src_a, w_illegal_inst;
    logic [1:0]  w_alu_src_b, w_alu_op;
    logic [3:0]  w_instret;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_ret = '0;

    // {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
    //  alu_src_a, alu_src_b[1:0], ALUOp[1:0], illegal_inst}
    wire [12:0] outs = {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
                        alu_src_a, alu_src_b, alu_op, illegal_inst};
    wire [12:0] w_outs = {w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_pc_src, w_reg_write,
                          w_mem_to_reg, w_alu_src_a, w_alu_src_b, w_alu_op, w_illegal_inst};

    localparam logic [12:0] O_IDLE       = 13'b0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] O_FETCH_WAIT = 13'b1_0_0_0_0_0_0_0_01_00_0;
    localparam logic [12:0] O_FETCH_RDY  = 13'b1_0_1_1_0_0_0_0_01_00_0;
    localparam logic [12:0] O_DECODE     = 13'b0_0_0_0_0_0_0_0_10_00_0;
    localparam logic [12:0] O_DECODE_ILL = 13'b0_0_0_0_0_0_0_0_10_00_1;
    localparam logic [12:0] O_EXEC_R     = 13'b0_0_0_0_0_0_0_1_00_10_0;
    localparam logic [12:0] O_EXEC_I     = 13'b0_0_0_0_0_0_0_1_10_11_0;
    localparam logic [12:0] O_MEM_ADDR   = 13'b0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [12:0] O_MEM_RD     = 13'b1_0_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] O_MEM_WR     = 13'b1_1_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] O_WB_ALU     = 13'b0_0_0_0_0_1_0_0_00_00_0;
    localparam logic [12:0] O_WB_MEM     = 13'b0_0_0_0_0_1_1_0_00_00_0;
    localparam logic [12:0] O_BR_TAKEN   = 13'b0_0_0_1_1_0_0_1_00_01_0;
    localparam logic [12:0] O_BR_NOT     = 13'b0_0_0_0_1_0_0_1_00_01_0;

    always #5 clk = ~clk;

    main_cu_fsm #(.W_INSTRET(32)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(alu_op),
        .illegal_inst(illegal_inst), .instret(instret)
    );

    main_cu_fsm #(.W_INSTRET(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .ir_write(w_ir_write),
        .pc_write(w_pc_write), .pc_src(w_pc_src), .reg_write(w_reg_write),
        .mem_to_reg(w_mem_to_reg), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .ALUOp(w_alu_op), .illegal_inst(w_illegal_inst), .instret(w_instret)
    );

    // Reset from any point; returns 1ns after the first FETCH edge.
    task automatic test_reset_basic();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #2;
        checks++;
        if (outs !== O_IDLE) begin
            failures++;
            $display("FAIL reset_outs got %b want %b", outs, O_IDLE);
        end
        checks++;
        if (instret !== 32'd0) begin
            failures++;
            $display("FAIL reset_instret got %0d want 0", instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            failures++;
            $display("FAIL idle_outs got %b want %b", outs, O_IDLE);
        end
        @(posedge clk);
        #1;
        exp_ret = '0;
        checks++;
        if (outs !== O_FETCH_WAIT) begin
            failures++;
            $display("FAIL first_fetch got %b want %b", outs, O_FETCH_WAIT);
        end
    endtask

    task automatic test_r_type();
        logic [12:0] exp_v [4] = '{O_FETCH_RDY, O_DECODE, O_EXEC_R, O_WB_ALU};
        inst = 32'h0000_0033;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs !== exp_v[i]) begin
                failures++;
                $display("FAIL r_type cycle %0d got %b want %b", i, outs, exp_v[i]);
            end
            @(posedge clk);
            #1;
        end
        exp_ret = exp_ret + 1;
        checks++;
        if (instret !== exp_ret) begin
            failures++;
            $display("FAIL r_type_instret got %0d want %0d", instret, exp_ret);
        end
    endtask

    task automatic test_i_type();
        logic [12:0] exp_v [4] = '{O_FETCH_RDY, O_DECODE, O_EXEC_I, O_WB_ALU};
        inst = 32'h0010_0093;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs !== exp_v[i]) begin
                failures++;
                $display("FAIL i_type cycle %0d got %b want %b", i, outs, exp_v[i]);
            end
            @(posedge clk);
            #1;
        end
        exp_ret = exp_ret + 1;
        checks++;
        if (instret !== exp_ret) begin
            failures++;
            $display("FAIL i_type_instret got %0d want %0d", instret, exp_ret);
        end
    endtask

    // Abort a load while it waits in MEM_RD.
    task automatic test_reset_mid_load();
        logic [12:0] exp_v [4] = '{O_FETCH_RDY, O_DECODE, O_MEM_ADDR, O_MEM_RD};
        logic        rdy_v [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        inst = 32'h0000_2003;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy_v[i];
            #1;
            checks++;
            if (outs !== exp_v[i]) begin
                failures++;
                $display("FAIL pre_abort cycle %0d got %b want %b", i, outs, exp_v[i]);
            end
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL abort_mem_req got %b want 0", mem_req);
        end
        checks++;
        if (instret !== 32'd0 || w_instret !== 4'd0) begin
            failures++;
            $display("FAIL abort_instret got %0d/%0d want 0/0", instret, w_instret);
        end
        @(posedge clk);
        #1;
        test_reset_basic();
    endtask

    task automatic test_lw_wait();
        logic [12:0] exp_v [7] = '{O_FETCH_RDY, O_DECODE, O_MEM_ADDR, O_MEM_RD, O_MEM_RD,
                                   O_MEM_RD, O_WB_MEM};
        logic        rdy_v [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int          req_cycles = 0;
        inst = 32'h0000_2003;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy_v[i];
            #1;
            if (i >= 3 && mem_req === 1'b1) req_cycles++;
            checks++;
            if (outs !== exp_v[i]) begin
                failures++;
                $display("FAIL lw cycle %0d got %b want %b", i, outs, exp_v[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (req_cycles != 3) begin
            failures++;
            $display("FAIL lw_req_hold got %0d want 3", req_cycles);
        end
        exp_ret = exp_ret + 1;
        checks++;
        if (instret !== exp_ret) begin
            failures++;
            $display("FAIL lw_instret got %0d want %0d", instret, exp_ret);
        end
    endtask

    task automatic test_sw_beq();
        logic [12:0] exp_v [10] = '{O_FETCH_RDY, O_DECODE, O_MEM_ADDR, O_MEM_WR,
                                    O_FETCH_RDY, O_DECODE, O_BR_TAKEN,
                                    O_FETCH_RDY, O_DECODE, O_BR_NOT};
        logic [31:0] inst_v [10] = '{32'h0000_2023, 32'h0000_2023, 32'h0000_2023,
                                     32'h0000_2023, 32'h0000_0063, 32'h0000_0063,
                                     32'h0000_0063, 32'h0000_0063, 32'h0000_0063,
                                     32'h0000_0063};
        logic        zero_v [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                     1'b1, 1'b1, 1'b0};
        logic [31:0] start_ret = exp_ret;
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inst = inst_v[i];
            zero = zero_v[i];
            #1;
            checks++;
            if (outs !== exp_v[i]) begin
                failures++;
                $display("FAIL sw_beq cycle %0d got %b want %b", i, outs, exp_v[i]);
            end
            @(posedge clk);
            #1;
        end
        zero = 1'b0;
        exp_ret = exp_ret + 3;
        checks++;
        if (instret !== exp_ret || instret - start_ret !== 32'd3) begin
            failures++;
            $display("FAIL sw_beq_instret got %0d want %0d", instret, exp_ret);
        end
    endtask

    task automatic test_illegal();
        logic [12:0] exp_v [3] = '{O_FETCH_RDY, O_DECODE_ILL, O_FETCH_WAIT};
        logic        rdy_v [3] = '{1'b1, 1'b1, 1'b0};
        int          pulses = 0;
        inst = 32'h0000_007F;
        for (int i = 0; i < 3; i++) begin
            mem_ready = rdy_v[i];
            #1;
            if (illegal_inst === 1'b1) pulses++;
            checks++;
            if (outs !== exp_v[i]) begin
                failures++;
                $display("FAIL illegal cycle %0d got %b want %b", i, outs, exp_v[i]);
            end
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL illegal_pulses got %0d want 1", pulses);
        end
        checks++;
        if (instret !== exp_ret) begin
            failures++;
            $display("FAIL illegal_instret got %0d want %0d", instret, exp_ret);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        test_reset_basic();
        inst = 32'h0000_0033;
        mem_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
            end
            exp_ret = exp_ret + 1;
            if (n == 14) begin
                checks++;
                if (w_instret !== 4'd15) begin
                    failures++;
                    $display("FAIL wrap_pre got %0d want 15", w_instret);
                end
            end
        end
        #1;
        checks++;
        if (w_instret !== 4'd0) begin
            failures++;
            $display("FAIL wrap_narrow got %0d want 0", w_instret);
        end
        checks++;
        if (instret !== 32'd16 || exp_ret !== 32'd16) begin
            failures++;
            $display("FAIL wrap_wide got %0d want 16", instret);
        end
        checks++;
        if (w_outs !== O_FETCH_RDY) begin
            failures++;
            $display("FAIL wrap_outs got %b want %b", w_outs, O_FETCH_RDY);
        end
    endtask

    initial begin
        test_reset_basic();
        test_r_type();
        test_reset_mid_load();
        test_lw_wait();
        test_sw_beq();
        test_illegal();
        test_i_type();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
